// File: rtl/window_accumulator.sv
// rtl/window_accumulator.sv - windowed sample accumulator with held, handshaked result (optional ACC_SAT_EN saturation)
module window_accumulator #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 12,
  parameter int WIN_LEN = 9,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] sample_cnt
);

  // Window position: ACCUM while collecting, LAST while waiting for the completing sample.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_LAST  = 1'b1
  } state_t;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_ovf;

  state_t           w_state;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_ovf_next;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_accept;
  logic             w_complete;

  // State is implied by the sample counter; no separate register needed.
  assign w_state = (r_cnt == CNT_W'(WIN_LEN - 1)) ? ST_LAST : ST_ACCUM;

  // One extra bit on the adder exposes the carry out of the accumulator.
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign w_carry    = w_sum[ACC_W];
  assign w_ovf_next = r_ovf | w_carry;

`ifdef ACC_SAT_EN
  // Once the window has overflowed, pin the sum at full scale until the window ends.
  assign w_acc_next = w_ovf_next ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  // Modulo wrap; overflow is still reported through out_ovf.
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // Only the completing sample can stall, and only while an unconsumed result is held.
  assign in_ready   = ~((w_state == ST_LAST) & r_out_valid & ~out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_complete = w_accept & (w_state == ST_LAST) & ~clr;

  // Accumulator, counter and sticky overflow; clr drops any sample offered that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_state == ST_LAST) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CNT_W'(1);
        r_ovf <= w_ovf_next;
      end
    end
  end

  // Result register: loads on window completion, otherwise holds until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_next;
      r_out_ovf   <= w_ovf_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ovf    = r_out_ovf;
  assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_window_accumulator.sv
// tb/tb_window_accumulator.sv - directed self-checking bench for window_accumulator
module tb_window_accumulator;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_ovf;
  logic [3:0]  sample_cnt;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic        out_valid8;
  logic [7:0]  out_data8;
  logic        out_ovf8;
  logic [3:0]  sample_cnt8;

  int n_total;
  int n_bad;

  window_accumulator #(.IN_W(8), .ACC_W(12), .WIN_LEN(9), .CNT_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .sample_cnt (sample_cnt)
  );

  window_accumulator #(.IN_W(8), .ACC_W(8), .WIN_LEN(9), .CNT_W(4)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .clr        (1'b0),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .in_data    (in_data8),
    .out_valid  (out_valid8),
    .out_ready  (1'b1),
    .out_data   (out_data8),
    .out_ovf    (out_ovf8),
    .sample_cnt (sample_cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    in_valid8 = 1'b0;
    in_data8  = 8'd0;
    step();
    step();

    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
    check_eq("rst_cnt", 32'(sample_cnt), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // 1: samples 1..9 back-to-back
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      if (i == 8) check_eq("t1_no_early_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_data", 32'(out_data), 32'd45);
    check_eq("t1_ovf", 32'(out_ovf), 32'd0);
    check_eq("t1_cnt", 32'(sample_cnt), 32'd0);
    step();
    check_eq("t1_valid_one_cycle", 32'(out_valid), 32'd0);

    // 2: result held with out_ready low, completing sample stalls
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    check_eq("t2_a_valid", 32'(out_valid), 32'd1);
    check_eq("t2_a_data", 32'(out_data), 32'd45);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd2;
      check_eq($sformatf("t2_ready_s%0d", i), 32'(in_ready), 32'd1);
      step();
    end
    in_data = 8'd2;
    check_eq("t2_stall_ready", 32'(in_ready), 32'd0);
    step();
    check_eq("t2_stall_cnt", 32'(sample_cnt), 32'd8);
    check_eq("t2_held_data", 32'(out_data), 32'd45);
    check_eq("t2_held_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check_eq("t2_release_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("t2_b_valid", 32'(out_valid), 32'd1);
    check_eq("t2_b_data", 32'(out_data), 32'd18);
    check_eq("t2_b_cnt", 32'(sample_cnt), 32'd0);

    // 4: clr with a 5th sample, pending result untouched
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd10;
      step();
    end
    check_eq("t4_cnt4", 32'(sample_cnt), 32'd4);
    clr     = 1'b1;
    in_data = 8'd10;
    step();
    clr = 1'b0;
    check_eq("t4_clr_cnt", 32'(sample_cnt), 32'd0);
    check_eq("t4_clr_valid", 32'(out_valid), 32'd1);
    check_eq("t4_clr_data", 32'(out_data), 32'd18);
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd1;
      step();
      if (i == 1) check_eq("t4_consumed", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("t4_valid", 32'(out_valid), 32'd1);
    check_eq("t4_data", 32'(out_data), 32'd9);
    check_eq("t4_ovf", 32'(out_ovf), 32'd0);
    step();

    // 5: in_valid toggling, idle cycles change nothing
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      in_valid = 1'b0;
      in_data  = 8'd99;
      if (i < 9) begin
        step();
        check_eq($sformatf("t5_idle_cnt%0d", i), 32'(sample_cnt), 32'(i));
      end
    end
    check_eq("t5_valid", 32'(out_valid), 32'd1);
    check_eq("t5_data", 32'(out_data), 32'd45);
    step();

    // 6: rst mid-window with a pending result
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      step();
    end
    check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
    check_eq("t6_pre_cnt", 32'(sample_cnt), 32'd4);
    rst     = 1'b1;
    in_data = 8'd5;
    step();
    rst = 1'b0;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_cnt", 32'(sample_cnt), 32'd0);
    check_eq("t6_rst_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    in_valid = 1'b0;
    check_eq("t6_valid", 32'(out_valid), 32'd1);
    check_eq("t6_data", 32'(out_data), 32'd45);

    // 3: ACC_W=8 overflow, 9 x 255 = 0x8F7
    for (int i = 1; i <= 9; i++) begin
      in_valid8 = 1'b1;
      in_data8  = 8'd255;
      step();
    end
    in_valid8 = 1'b0;
    check_eq("t3_valid", 32'(out_valid8), 32'd1);
`ifdef ACC_SAT_EN
    check_eq("t3_data_sat", 32'(out_data8), 32'hFF);
`else
    check_eq("t3_data_wrap", 32'(out_data8), 32'hF7);
`endif
    check_eq("t3_ovf", 32'(out_ovf8), 32'd1);
    check_eq("t3_cnt", 32'(sample_cnt8), 32'd0);
    step();
    check_eq("t3_valid_clear", 32'(out_valid8), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
